// File: rtl/interrupt_ctrl.sv
// Interrupt front-end for the mips core: synchronises raw lines, captures rising edges as
// pending bits, masks them and hands one prioritised request (with cause ID) to the core.
module interrupt_ctrl #(
    parameter int                  NUM_SRC  = 4,
    parameter int                  ID_W     = 2,
    parameter logic [NUM_SRC-1:0]  MASK_RST = 4'hF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  irq_in,
    input  logic                mask_we,
    input  logic [NUM_SRC-1:0]  mask_wdata,
    input  logic                int_ack,
    input  logic                int_eret,
    output logic                int_req,
    output logic [ID_W-1:0]     int_cause,
    output logic [NUM_SRC-1:0]  pending,
    output logic [NUM_SRC-1:0]  mask,
    output logic                in_service
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     cause_reg, cause_next;
    logic                int_req_reg, int_req_next;
    logic                in_service_reg, in_service_next;

    logic [NUM_SRC-1:0]  s1_reg, s2_reg, s3_reg;
    logic [NUM_SRC-1:0]  pending_reg, pending_next;
    logic [NUM_SRC-1:0]  mask_reg;
    logic [NUM_SRC-1:0]  edge_det;
    logic [NUM_SRC-1:0]  clr;
    logic [NUM_SRC-1:0]  active;
    logic [ID_W-1:0]     first_idx;

    // s1/s2 form the synchroniser; s3 remembers the previous synchronised level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_reg <= '0;
            s2_reg <= '0;
            s3_reg <= '0;
        end else begin
            s1_reg <= irq_in;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    // A fresh edge sets the bit even in the cycle its previous occurrence is acknowledged.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign edge_det[gi]     = s2_reg[gi] & ~s3_reg[gi];
            assign pending_next[gi] = (pending_reg[gi] & ~clr[gi]) | edge_det[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_reg <= '0;
            mask_reg    <= MASK_RST;
        end else begin
            pending_reg <= pending_next;
            if (mask_we) begin
                mask_reg <= mask_wdata;
            end
        end
    end

    assign active = pending_reg & mask_reg;

    // Lowest index wins; scanning downwards leaves the lowest set index last.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                first_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        cause_next      = cause_reg;
        int_req_next    = 1'b0;
        in_service_next = 1'b0;
        clr             = '0;
        case (state_reg)
            IDLE: begin
                if (|active) begin
                    state_next   = REQ;
                    cause_next   = first_idx;
                    int_req_next = 1'b1;
                end
            end
            REQ: begin
                // An eret arriving with the ack is dropped: the handler has not run yet.
                if (int_ack) begin
                    clr[cause_reg]  = 1'b1;
                    state_next      = SVC;
                    in_service_next = 1'b1;
                end else begin
                    int_req_next = 1'b1;
                end
            end
            SVC: begin
                if (int_eret) begin
                    state_next = IDLE;
                end else begin
                    in_service_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cause_reg      <= '0;
            int_req_reg    <= 1'b0;
            in_service_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cause_reg      <= cause_next;
            int_req_reg    <= int_req_next;
            in_service_reg <= in_service_next;
        end
    end

    assign int_req    = int_req_reg;
    assign int_cause  = cause_reg;
    assign in_service = in_service_reg;
    assign pending    = pending_reg;
    assign mask       = mask_reg;

endmodule
